// File: rtl/dma_seq_pkg.sv
// Shared definitions for the DMA transfer sequencer: sequencer states and
// default widths that match the downstream address generator.
package dma_seq_pkg;

    localparam int ADDR_WIDTH_DEF = 16;
    localparam int LEN_WIDTH_DEF  = 12;
    localparam int PASS_WIDTH_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARM    = 3'd1,
        ST_STREAM = 3'd2,
        ST_GAP    = 3'd3,
        ST_FINISH = 3'd4
    } seq_state_t;

endpackage

// File: rtl/dma_transfer_sequencer_counter.sv
// Saturating up-counter with synchronous clear. o_terminal flags that the
// next increment would reach i_limit, so the caller can act on the final
// beat/pass before the count moves; the count never runs past i_limit.
module xfer_beat_counter #(
    parameter int WIDTH = 12
) (
    input  logic             core_clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_terminal
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH:0]   w_count_plus_one;

    assign w_count_plus_one = {1'b0, r_count} + {{WIDTH{1'b0}}, 1'b1};
    assign o_terminal       = (w_count_plus_one == {1'b0, i_limit});

    // Count enabled events; clear wins, and the count holds once at the limit.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_clear) begin
            r_count <= {WIDTH{1'b0}};
        end else if (i_enable && (r_count != i_limit)) begin
            r_count <= w_count_plus_one[WIDTH-1:0];
        end else begin
            r_count <= r_count;
        end
    end

endmodule

// File: rtl/dma_transfer_sequencer.sv
// Command-driven sequencer feeding the address generator. Accepts one
// transfer command, paces data beats through valid/ready, replays the region
// for multiple passes (one increment-low GAP cycle between passes acts as the
// generator's rewind event) and pulses done on completion.
module dma_transfer_sequencer
    import dma_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF,
    parameter int PASS_WIDTH = PASS_WIDTH_DEF
) (
    input  logic                  core_clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [PASS_WIDTH-1:0] cmd_passes,
    input  logic                  cmd_back_path,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    input  logic                  abort,
    output logic                  agen_enable,
    output logic                  agen_transfer,
    output logic                  agen_increment,
    output logic [ADDR_WIDTH-1:0] agen_base_address,
    output logic                  agen_direct_back_path,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted
);

    seq_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [PASS_WIDTH-1:0] r_passes;
    logic                  r_back_path;
    logic                  r_aborted;

    logic                  w_accept;
    logic                  w_beat_last;
    logic                  w_pass_last;
    logic                  w_beat_clear;
    logic                  w_pass_en;
    logic [PASS_WIDTH-1:0] w_passes_eff;

    // Beat path is combinational so a beat can be taken every STREAM cycle.
    assign beat_ready     = (r_state == ST_STREAM) && !abort;
    assign agen_increment = beat_ready && beat_valid;

    assign cmd_ready      = (r_state == ST_IDLE) && !reset;
    assign busy           = (r_state != ST_IDLE);
    assign done           = (r_state == ST_FINISH);
    assign aborted        = r_aborted;
    assign agen_enable    = (r_state == ST_ARM) || (r_state == ST_STREAM) || (r_state == ST_GAP);
    assign agen_transfer  = agen_enable;

    assign agen_base_address     = r_base;
    assign agen_direct_back_path = r_back_path;

    assign w_accept     = (r_state == ST_IDLE) && cmd_valid;
    assign w_beat_clear = w_accept || (r_state == ST_GAP);
    assign w_pass_en    = (r_state == ST_GAP);

    // Effective pass count: write-back is always one pass, and zero means one.
    always_comb begin
        w_passes_eff = cmd_passes;
        if (cmd_back_path) begin
            w_passes_eff = {{(PASS_WIDTH-1){1'b0}}, 1'b1};
        end else if (cmd_passes == {PASS_WIDTH{1'b0}}) begin
            w_passes_eff = {{(PASS_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            w_passes_eff = cmd_passes;
        end
    end

    xfer_beat_counter #(.WIDTH(LEN_WIDTH)) u_beat_cnt (
        .core_clk   (core_clk),
        .reset      (reset),
        .i_clear    (w_beat_clear),
        .i_enable   (agen_increment),
        .i_limit    (r_len),
        .o_terminal (w_beat_last)
    );

    xfer_beat_counter #(.WIDTH(PASS_WIDTH)) u_pass_cnt (
        .core_clk   (core_clk),
        .reset      (reset),
        .i_clear    (w_accept),
        .i_enable   (w_pass_en),
        .i_limit    (r_passes),
        .o_terminal (w_pass_last)
    );

    // Sequencer FSM: command latch, state transitions and the abort flag.
    always_ff @(posedge core_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_base      <= {ADDR_WIDTH{1'b0}};
            r_len       <= {LEN_WIDTH{1'b0}};
            r_passes    <= {PASS_WIDTH{1'b0}};
            r_back_path <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_aborted <= 1'b0;
                    if (cmd_valid) begin
                        r_base      <= cmd_base_addr;
                        r_len       <= cmd_len;
                        r_passes    <= w_passes_eff;
                        r_back_path <= cmd_back_path;
                        if (cmd_len == {LEN_WIDTH{1'b0}}) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_ARM;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ARM: begin
                    if (abort) begin
                        r_state   <= ST_FINISH;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_state   <= ST_FINISH;
                        r_aborted <= 1'b1;
                    end else if (agen_increment && w_beat_last) begin
                        if (w_pass_last) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        r_state   <= ST_FINISH;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_FINISH: begin
                    r_state   <= ST_IDLE;
                    r_aborted <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_aborted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_transfer_sequencer.sv
// Directed self-checking bench for dma_transfer_sequencer.
module tb_dma_transfer_sequencer;

    logic        core_clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_base_addr;
    logic [11:0] cmd_len;
    logic [3:0]  cmd_passes;
    logic        cmd_back_path;
    logic        beat_valid;
    logic        beat_ready;
    logic        abort;
    logic        agen_enable;
    logic        agen_transfer;
    logic        agen_increment;
    logic [15:0] agen_base_address;
    logic        agen_direct_back_path;
    logic        busy;
    logic        done;
    logic        aborted;

    int n_checks = 0;
    int n_fail   = 0;

    int incs, gaps, dones, aborts, cyc, done_cyc, first_inc, last_inc;

    always #5 core_clk = ~core_clk;

    dma_transfer_sequencer dut (
        .core_clk              (core_clk),
        .reset                 (reset),
        .cmd_valid             (cmd_valid),
        .cmd_ready             (cmd_ready),
        .cmd_base_addr         (cmd_base_addr),
        .cmd_len               (cmd_len),
        .cmd_passes            (cmd_passes),
        .cmd_back_path         (cmd_back_path),
        .beat_valid            (beat_valid),
        .beat_ready            (beat_ready),
        .abort                 (abort),
        .agen_enable           (agen_enable),
        .agen_transfer         (agen_transfer),
        .agen_increment        (agen_increment),
        .agen_base_address     (agen_base_address),
        .agen_direct_back_path (agen_direct_back_path),
        .busy                  (busy),
        .done                  (done),
        .aborted               (aborted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    // Offer one command for a single edge; afterwards we sit in cycle 1 after accept.
    task automatic send_cmd(input logic [15:0] base, input logic [11:0] len,
                            input logic [3:0] passes, input logic back);
        cmd_base_addr = base;
        cmd_len       = len;
        cmd_passes    = passes;
        cmd_back_path = back;
        cmd_valid     = 1'b1;
        step();
        cmd_valid     = 1'b0;
        #1;
    endtask

    // Observe cycles until cmd_ready returns; cyc counts cycles since the accept edge.
    task automatic run_to_idle(input int budget, input bit toggle);
        incs = 0; gaps = 0; dones = 0; aborts = 0; cyc = 1;
        done_cyc = -1; first_inc = -1; last_inc = -1;
        while (!cmd_ready && cyc < budget) begin
            if (toggle) beat_valid = ~beat_valid;
            #1;
            if (agen_increment) begin
                incs++;
                if (first_inc < 0) first_inc = cyc;
                last_inc = cyc;
            end
            if (agen_transfer && !beat_ready && incs > 0) gaps++;
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (aborted) aborts++;
            step();
            cyc++;
        end
        chk("idle_timeout", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_base_addr = 16'h0000; cmd_len = 12'd0;
        cmd_passes = 4'd0; cmd_back_path = 1'b0; beat_valid = 1'b0; abort = 1'b0;
        #2;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_enable",    32'(agen_enable), 32'd0);
        chk("rst_base",      32'(agen_base_address), 32'd0);
        step();
        reset = 1'b0;
        #1;
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_beat_ready", 32'(beat_ready), 32'd0);

        // Single pass, len 4, continuous beats.
        beat_valid = 1'b1;
        send_cmd(16'h0040, 12'd4, 4'd1, 1'b0);
        chk("t1_arm_enable",   32'(agen_enable), 32'd1);
        chk("t1_arm_transfer", 32'(agen_transfer), 32'd1);
        chk("t1_arm_inc",      32'(agen_increment), 32'd0);
        chk("t1_arm_ready",    32'(cmd_ready), 32'd0);
        chk("t1_base",         32'(agen_base_address), 32'h0040);
        run_to_idle(40, 1'b0);
        chk("t1_incs",      32'(incs), 32'd4);
        chk("t1_first_inc", 32'(first_inc), 32'd2);
        chk("t1_last_inc",  32'(last_inc), 32'd5);
        chk("t1_done_cyc",  32'(done_cyc), 32'd6);
        chk("t1_dones",     32'(dones), 32'd1);
        chk("t1_aborts",    32'(aborts), 32'd0);
        chk("t1_cycles",    32'(cyc), 32'd7);
        chk("t1_base_hold", 32'(agen_base_address), 32'h0040);

        // Three passes of 3 beats with a GAP between passes.
        send_cmd(16'h1230, 12'd3, 4'd3, 1'b0);
        run_to_idle(60, 1'b0);
        chk("t2_incs",     32'(incs), 32'd9);
        chk("t2_gaps",     32'(gaps), 32'd2);
        chk("t2_dones",    32'(dones), 32'd1);
        chk("t2_done_cyc", 32'(done_cyc), 32'd13);
        chk("t2_cycles",   32'(cyc), 32'd14);

        // Write-back forces a single pass.
        send_cmd(16'hBEEF, 12'd3, 4'd5, 1'b1);
        chk("t3_back_path", 32'(agen_direct_back_path), 32'd1);
        chk("t3_base",      32'(agen_base_address), 32'hBEEF);
        run_to_idle(60, 1'b0);
        chk("t3_incs",     32'(incs), 32'd3);
        chk("t3_gaps",     32'(gaps), 32'd0);
        chk("t3_done_cyc", 32'(done_cyc), 32'd5);
        chk("t3_cycles",   32'(cyc), 32'd6);

        // Zero length goes straight to FINISH.
        send_cmd(16'h0100, 12'd0, 4'd2, 1'b0);
        chk("t4_done",   32'(done), 32'd1);
        chk("t4_enable", 32'(agen_enable), 32'd0);
        run_to_idle(20, 1'b0);
        chk("t4_incs",     32'(incs), 32'd0);
        chk("t4_done_cyc", 32'(done_cyc), 32'd1);
        chk("t4_cycles",   32'(cyc), 32'd2);

        // len 8 with beat_valid alternating each cycle.
        beat_valid = 1'b1;
        send_cmd(16'h0200, 12'd8, 4'd1, 1'b0);
        run_to_idle(80, 1'b1);
        chk("t5_incs",     32'(incs), 32'd8);
        chk("t5_first",    32'(first_inc), 32'd2);
        chk("t5_last",     32'(last_inc), 32'd16);
        chk("t5_done_cyc", 32'(done_cyc), 32'd17);
        chk("t5_cycles",   32'(cyc), 32'd18);

        // Abort after the second beat of a 6-beat transfer.
        beat_valid = 1'b1;
        send_cmd(16'h0300, 12'd6, 4'd1, 1'b0);
        step();
        chk("t6_beat1", 32'(agen_increment), 32'd1);
        step();
        chk("t6_beat2", 32'(agen_increment), 32'd1);
        step();
        abort = 1'b1;
        #1;
        chk("t6_abort_ready", 32'(beat_ready), 32'd0);
        chk("t6_abort_inc",   32'(agen_increment), 32'd0);
        step();
        abort = 1'b0;
        chk("t6_done",     32'(done), 32'd1);
        chk("t6_aborted",  32'(aborted), 32'd1);
        chk("t6_transfer", 32'(agen_transfer), 32'd0);
        step();
        chk("t6_idle",        32'(cmd_ready), 32'd1);
        chk("t6_aborted_off", 32'(aborted), 32'd0);
        chk("t6_done_off",    32'(done), 32'd0);

        // Reset asserted in the middle of STREAM.
        send_cmd(16'h0400, 12'd5, 4'd1, 1'b0);
        step();
        chk("t7_streaming", 32'(agen_increment), 32'd1);
        reset = 1'b1;
        #1;
        chk("t7_rst_busy",     32'(busy), 32'd0);
        chk("t7_rst_transfer", 32'(agen_transfer), 32'd0);
        chk("t7_rst_inc",      32'(agen_increment), 32'd0);
        chk("t7_rst_ready",    32'(cmd_ready), 32'd0);
        chk("t7_rst_base",     32'(agen_base_address), 32'd0);
        step();
        chk("t7_rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        #1;
        chk("t7_post_ready", 32'(cmd_ready), 32'd1);
        step();
        chk("t7_post_done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
